// File: rtl/change_dispenser_if.sv
// Bus between the upstream vending FSM, the soda/coin mechanism and the dispenser.
// Requests are levels held until the matching ack is sampled high on a rising edge.
interface change_dispenser_if;
    logic       i_soda;
    logic [2:0] i_change;
    logic       o_vend_req;
    logic       i_vend_ack;
    logic       o_coin_req;
    logic       o_coin_dime;
    logic       i_coin_ack;
    logic       o_busy;
    logic [2:0] o_fifo_count;
    logic       o_overflow;
    logic       o_err;

    modport slave (
        input  i_soda, i_change, i_vend_ack, i_coin_ack,
        output o_vend_req, o_coin_req, o_coin_dime, o_busy, o_fifo_count, o_overflow, o_err
    );

    modport master (
        output i_soda, i_change, i_vend_ack, i_coin_ack,
        input  o_vend_req, o_coin_req, o_coin_dime, o_busy, o_fifo_count, o_overflow, o_err
    );
endinterface

// File: rtl/change_dispenser.sv
// Queues vend requests in a 4-deep FIFO and serves each as one soda drop
// followed by the change paid out greedily in dimes, then at most one nickel.
module change_dispenser (
    input  logic                i_clk,
    input  logic                ni_rst,
    change_dispenser_if.slave   bus,
    output logic [1:0]          o_dbg_state
);
    typedef enum logic [1:0] {IDLE = 2'd0, VEND = 2'd1, COIN = 2'd2} state_e;

    state_e     state_q, state_d;
    logic [2:0] rem_q, rem_d;
    logic [2:0] mem_q [4];
    logic [2:0] mem_d [4];
    logic [1:0] wr_ptr_q, wr_ptr_d;
    logic [1:0] rd_ptr_q, rd_ptr_d;
    logic [2:0] count_q, count_d;
    logic       ovf_q, ovf_d;
    logic       err_q, err_d;

    logic       pop;
    logic       push;
    logic       illegal;
    logic [2:0] wdata;
    logic [2:0] rem_next;

    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        err_d    = err_q;
        rem_next = rem_q;

        // A full FIFO still accepts a write when the head leaves on the same edge.
        pop     = (state_q == IDLE) && (count_q != 3'd0);
        push    = bus.i_soda && ((count_q < 3'd4) || pop);
        illegal = bus.i_soda && (bus.i_change > 3'd4);
        wdata   = (bus.i_change > 3'd4) ? 3'd0 : bus.i_change;

        case (state_q)
            IDLE: begin
                if (pop) begin
                    rem_d    = mem_q[rd_ptr_q];
                    rd_ptr_d = rd_ptr_q + 2'd1;
                    state_d  = VEND;
                end
            end
            VEND: begin
                if (bus.i_vend_ack) begin
                    state_d = (rem_q == 3'd0) ? IDLE : COIN;
                end
            end
            COIN: begin
                if (bus.i_coin_ack) begin
                    rem_next = (rem_q >= 3'd2) ? (rem_q - 3'd2) : (rem_q - 3'd1);
                    rem_d    = rem_next;
                    if (rem_next == 3'd0) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + 2'd1;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 3'd1;
            2'b01:   count_d = count_q - 3'd1;
            default: count_d = count_q;
        endcase

        if (bus.i_soda && !push) begin
            ovf_d = 1'b1;
        end
        if (illegal) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge ni_rst) begin
        if (!ni_rst) begin
            state_q  <= IDLE;
            rem_q    <= 3'd0;
            mem_q    <= '{default: 3'd0};
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            count_q  <= 3'd0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            err_q    <= err_d;
        end
    end

    // Requests decode only registered state so acks never reach them combinationally.
    assign bus.o_vend_req   = (state_q == VEND);
    assign bus.o_coin_req   = (state_q == COIN);
    assign bus.o_coin_dime  = (state_q == COIN) && (rem_q >= 3'd2);
    assign bus.o_busy       = (state_q != IDLE) || (count_q != 3'd0);
    assign bus.o_fifo_count = count_q;
    assign bus.o_overflow   = ovf_q;
    assign bus.o_err        = err_q;
    assign o_dbg_state      = state_q;
endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: directed vector table, corner sequences and
// random traffic checked against a transaction-level queue model.
module tb_change_dispenser;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] dbg_state;
  int         n_checks = 0;
  int         n_pass   = 0;

  always #5 clk = ~clk;

  change_dispenser_if bus ();

  change_dispenser dut (
    .i_clk       (clk),
    .ni_rst      (rst_n),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // Model: pending change values in nickels, and the coins still owed.
  int pend_q[$];
  bit coin_q[$];
  bit m_active;
  bit m_vending;
  bit m_ovf;
  bit m_err;

  typedef struct {
    bit         soda;
    logic [2:0] chg;
    bit         vack;
    bit         cack;
    bit         e_vend;
    bit         e_coin;
    bit         e_dime;
    bit         e_busy;
    int         e_count;
    bit         e_err;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit s, int c, bit va, bit ca, bit ev, bit ec, bit ed, bit eb, int en, bit ee);
    vec_t v;
    v.soda = s; v.chg = 3'(c); v.vack = va; v.cack = ca;
    v.e_vend = ev; v.e_coin = ec; v.e_dime = ed; v.e_busy = eb; v.e_count = en; v.e_err = ee;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    pend_q.delete();
    coin_q.delete();
    m_active = 0; m_vending = 0; m_ovf = 0; m_err = 0;
  endtask

  task automatic model_edge(input bit soda, input int chg, input bit vack, input bit cack);
    int pre;
    bit pop_now;
    int v;
    bit dummy;
    pre     = pend_q.size();
    pop_now = !m_active && (pre > 0);
    if (m_active && m_vending) begin
      if (vack) begin
        m_vending = 0;
        if (coin_q.size() == 0) m_active = 0;
      end
    end else if (m_active) begin
      if (cack) begin
        dummy = coin_q.pop_front();
        if (coin_q.size() == 0) m_active = 0;
      end
    end
    if (pop_now) begin
      v = pend_q.pop_front();
      m_active = 1; m_vending = 1;
      coin_q.delete();
      while (v >= 2) begin coin_q.push_back(1'b1); v -= 2; end
      if (v == 1) coin_q.push_back(1'b0);
    end
    if (soda) begin
      if (chg > 4) m_err = 1;
      if (pre < 4 || pop_now) pend_q.push_back((chg > 4) ? 0 : chg);
      else m_ovf = 1;
    end
  endtask

  task automatic check_outputs();
    bit e_coin;
    bit e_dime;
    e_coin = m_active && !m_vending;
    e_dime = e_coin && (coin_q.size() > 0) && coin_q[0];
    check("vend_req",   bus.o_vend_req,   m_active && m_vending);
    check("coin_req",   bus.o_coin_req,   e_coin);
    check("coin_dime",  bus.o_coin_dime,  e_dime);
    check("busy",       bus.o_busy,       m_active || (pend_q.size() > 0));
    check("fifo_count", bus.o_fifo_count, pend_q.size());
    check("overflow",   bus.o_overflow,   m_ovf);
    check("err",        bus.o_err,        m_err);
  endtask

  task automatic drive(input bit soda, input int chg, input bit vack, input bit cack);
    bus.i_soda     = soda;
    bus.i_change   = 3'(chg);
    bus.i_vend_ack = vack;
    bus.i_coin_ack = cack;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge(bus.i_soda, int'(bus.i_change), bus.i_vend_ack, bus.i_coin_ack);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    check("reset_state", dbg_state, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int guard;
    drive(0, 0, 0, 0);
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs();
    check("reset_state", dbg_state, 0);
    rst_n = 1'b1;

    // 20c, 15c, 0c, 5c, illegal, stray acks, then a legal 10c after the error.
    tbl.push_back(mk(1, 4, 0, 0, 0, 0, 0, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 1, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 1, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 3, 0, 0, 0, 0, 0, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 1, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 6, 0, 0, 0, 0, 0, 1, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 1, 0, 1));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 2, 0, 0, 0, 0, 0, 1, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 1, 0, 1));
    tbl.push_back(mk(0, 0, 1, 0, 0, 1, 1, 1, 0, 1));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 1));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].soda, int'(tbl[i].chg), tbl[i].vack, tbl[i].cack);
      cycle();
      check($sformatf("tbl%0d_vend", i),  bus.o_vend_req,   tbl[i].e_vend);
      check($sformatf("tbl%0d_coin", i),  bus.o_coin_req,   tbl[i].e_coin);
      check($sformatf("tbl%0d_dime", i),  bus.o_coin_dime,  tbl[i].e_dime);
      check($sformatf("tbl%0d_busy", i),  bus.o_busy,       tbl[i].e_busy);
      check($sformatf("tbl%0d_count", i), bus.o_fifo_count, tbl[i].e_count);
      check($sformatf("tbl%0d_err", i),   bus.o_err,        tbl[i].e_err);
    end
    drive(0, 0, 0, 0);

    // Vend ack withheld for ten cycles, then the coin phase runs.
    do_reset();
    drive(1, 3, 0, 0); cycle();
    drive(0, 0, 0, 0); cycle();
    for (int i = 0; i < 10; i++) begin
      cycle();
      check("stall_vend", bus.o_vend_req, 1);
      check("stall_coin", bus.o_coin_req, 0);
    end
    drive(0, 0, 1, 0); cycle();
    check("stall_dime", bus.o_coin_dime, 1);
    drive(0, 0, 0, 1); cycle();
    check("stall_nickel", bus.o_coin_dime, 0);
    cycle();
    check("stall_done", bus.o_busy, 0);
    drive(0, 0, 0, 0);

    // Back-to-back pulses with acks withheld, then drain in order.
    for (int i = 0; i < 5; i++) begin
      drive(1, 4 - i, 0, 0);
      cycle();
    end
    check("burst_count", bus.o_fifo_count, 4);
    check("burst_ovf", bus.o_overflow, 0);
    drive(1, 1, 0, 0); cycle();
    check("burst_ovf_set", bus.o_overflow, 1);
    drive(0, 0, 1, 1);
    guard = 0;
    while ((m_active || pend_q.size() > 0) && guard < 60) begin
      cycle();
      guard++;
    end
    check("drain_in_budget", (guard < 60) ? 1 : 0, 1);
    check("drain_idle", bus.o_busy, 0);
    drive(0, 0, 0, 0);

    // Reset during COIN with two entries queued.
    do_reset();
    drive(1, 4, 0, 0); cycle();
    drive(1, 2, 0, 0); cycle();
    drive(1, 3, 1, 0); cycle();
    drive(0, 0, 0, 0);
    check("pre_reset_coin", bus.o_coin_req, 1);
    check("pre_reset_count", bus.o_fifo_count, 2);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_coin_req", bus.o_coin_req, 0);
    check("async_count", bus.o_fifo_count, 0);
    check("async_busy", bus.o_busy, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("post_reset_state", dbg_state, 0);
    end

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
      end
      drive(($urandom_range(0, 3) == 0), $urandom_range(0, 7),
            $urandom_range(0, 1), $urandom_range(0, 1));
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
